// File: rtl/data_memory_responder.sv
`default_nettype none
// ============================================================================
//  Module   : data_memory_responder
//  Purpose  : Word-organised data RAM behind valid/ready request and response
//             channels, with a fixed, parameterised access latency. Only one
//             transaction is in flight at a time.
//  Ports    : clk, rst_n          - clock (rising edge), async active-low reset
//             req_valid/req_ready - request handshake
//             req_address         - byte address (word aligned)
//             req_write           - 1 = store, 0 = load
//             req_wdata/req_strobe- store data and byte-lane enables
//             resp_valid/resp_ready - response handshake
//             resp_rdata          - load data (0 for stores and errors)
//             resp_error          - misaligned or out-of-range access
//  Revision : 1.0  initial release
// ============================================================================
module data_memory_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int LATENCY     = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_address,
  input  logic        req_write,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_strobe,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_error
);

  localparam int          AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] C_DEPTH     = 32'(DEPTH_WORDS);
  localparam logic [3:0]  C_CNT_START = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [3:0]  r_count;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        r_write;
  logic [3:0]  r_strobe;

  logic [31:0] mem [DEPTH_WORDS];

  logic        w_accept;
  logic        w_enter_resp;
  logic        w_use_req;
  logic [31:0] w_addr;
  logic [31:0] w_wdata;
  logic        w_write;
  logic [3:0]  w_strobe;
  logic        w_error;
  logic [AW-1:0] w_index;
  logic        w_mem_we;

  assign w_accept = req_valid && (r_state == IDLE);

  // With LATENCY==1 the RAM access happens on the accepting edge itself, so
  // the live request fields are used; otherwise the latched copies are used.
  assign w_enter_resp = (LATENCY == 1) ? w_accept
                                       : ((r_state == WAIT) && (r_count == 4'd1));
  assign w_use_req = (r_state == IDLE);
  assign w_addr    = w_use_req ? req_address : r_addr;
  assign w_wdata   = w_use_req ? req_wdata   : r_wdata;
  assign w_write   = w_use_req ? req_write   : r_write;
  assign w_strobe  = w_use_req ? req_strobe  : r_strobe;

  assign w_error = (w_addr[1:0] != 2'b00) || ({2'b00, w_addr[31:2]} >= C_DEPTH);
  assign w_index = w_addr[AW+1:2];

  // rst_n gating keeps a request presented during reset from committing.
  assign w_mem_we = rst_n && w_enter_resp && w_write && !w_error;

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state and handshake outputs
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_next = (LATENCY == 1) ? RESP : WAIT;
        end
      end
      WAIT: begin
        if (r_count == 4'd1) begin
          w_state_next = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Request capture, latency counter and response registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count    <= 4'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_write    <= 1'b0;
      r_strobe   <= 4'd0;
      resp_rdata <= 32'd0;
      resp_error <= 1'b0;
    end else begin
      if (w_accept) begin
        r_addr   <= req_address;
        r_wdata  <= req_wdata;
        r_write  <= req_write;
        r_strobe <= req_strobe;
        r_count  <= C_CNT_START;
      end else if (r_state == WAIT) begin
        r_count <= r_count - 4'd1;
      end

      if (w_enter_resp) begin
        resp_error <= w_error;
        resp_rdata <= (!w_write && !w_error) ? mem[w_index] : 32'd0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // RAM array: not reset, byte-lane writes
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (w_mem_we && w_strobe[i]) begin
        mem[w_index][8*i +: 8] <= w_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
